// File: rtl/alu_pkg.sv
// Shared opcode encodings, immediate-class decode helpers and operand-stage FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // Register-register ALU operations
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b000100;
    localparam logic [5:0] OP_OR    = 6'b000110;
    localparam logic [5:0] OP_XOR   = 6'b001000;
    localparam logic [5:0] OP_SLT   = 6'b010000;
    localparam logic [5:0] OP_OUT   = 6'b111111;

    // Immediate variants taking a sign-extended immediate
    localparam logic [5:0] OP_ADDI  = 6'b000001;
    localparam logic [5:0] OP_SUBI  = 6'b000011;
    localparam logic [5:0] OP_SLTI  = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b000111;
    localparam logic [5:0] OP_LDI   = 6'b001010;
    localparam logic [5:0] OP_SLLI  = 6'b010011;

    // Logical immediates take a zero-extended immediate
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001110;

    // Skid-buffer occupancy: nothing held, main only, main plus skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // True for every opcode whose operand B comes from the immediate field
    function automatic logic is_imm(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SLTI) ||
               (op == OP_XORI) || (op == OP_LDI)  || (op == OP_SLLI) ||
               (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    // True for the immediate opcodes that zero-extend instead of sign-extend
    function automatic logic is_zext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/alu_operand_mux.sv
// Resolves operands A/B: zero-register, writeback forwarding, immediate extension.
// Latency: combinational.
// Backpressure: none; evaluated only when the parent captures.
module alu_operand_mux
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_W  = 5
) (
    input  logic [5:0]        opcode,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [IMM_W-1:0]  imm,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b
);

    logic [DATA_W-1:0] rt_fwd;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;

    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};

    // Source values: register 0 is hardwired zero, otherwise prefer the in-flight writeback
    always_comb begin
        data_a = rs_val;
        rt_fwd = rt_val;
        if (rs == '0) begin
            data_a = '0;
        end else if (wb_valid && (wb_dest == rs)) begin
            data_a = wb_data;
        end
        if (rt == '0) begin
            rt_fwd = '0;
        end else if (wb_valid && (wb_dest == rt)) begin
            rt_fwd = wb_data;
        end
    end

    // Operand B: immediate class decides extension, otherwise the forwarded rt value
    always_comb begin
        data_b = rt_fwd;
        if (is_imm(opcode)) begin
            data_b = is_zext(opcode) ? imm_zext : imm_sext;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU issue stage: captures resolved operands into a 2-entry skid buffer (main + skid).
// Latency: 1 cycle from input handshake to out_valid when empty.
// Backpressure: in_ready is registered; drops only after two entries are held.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [REG_W-1:0]  in_dest,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_dataA,
    output logic [DATA_W-1:0] alu_dataB,
    output logic [REG_W-1:0]  out_dest
);

    stage_state_t state, state_nxt;
    logic in_xfer, out_xfer;
    logic load_main, load_skid, skid_to_main;

    logic [DATA_W-1:0] cap_a, cap_b;

    logic [5:0]        skid_opcode;
    logic [DATA_W-1:0] skid_a, skid_b;
    logic [REG_W-1:0]  skid_dest;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_valid = (state != EMPTY);

    alu_operand_mux #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .REG_W  (REG_W)
    ) u_mux (
        .opcode   (in_opcode),
        .rs       (in_rs),
        .rt       (in_rt),
        .rs_val   (in_rs_val),
        .rt_val   (in_rt_val),
        .imm      (in_imm),
        .wb_valid (wb_valid),
        .wb_dest  (wb_dest),
        .wb_data  (wb_data),
        .data_a   (cap_a),
        .data_b   (cap_b)
    );

    // Occupancy register; in_ready is registered alongside so it never depends on out_ready
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
        end
    end

    // Next occupancy and which register loads; flush overrides every transfer
    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (!in_xfer && out_xfer) begin
                    state_nxt = EMPTY;
                end else if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_nxt    = ONE;
                    skid_to_main = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt    = EMPTY;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
        end
    end

    // Main (output) register: fresh capture or promotion of the older skid entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_opcode <= '0;
            alu_dataA  <= '0;
            alu_dataB  <= '0;
            out_dest   <= '0;
        end else if (load_main) begin
            alu_opcode <= in_opcode;
            alu_dataA  <= cap_a;
            alu_dataB  <= cap_b;
            out_dest   <= in_dest;
        end else if (skid_to_main) begin
            alu_opcode <= skid_opcode;
            alu_dataA  <= skid_a;
            alu_dataB  <= skid_b;
            out_dest   <= skid_dest;
        end
    end

    // Skid register: holds the second entry while the ALU side stalls
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            skid_opcode <= '0;
            skid_a      <= '0;
            skid_b      <= '0;
            skid_dest   <= '0;
        end else if (load_skid) begin
            skid_opcode <= in_opcode;
            skid_a      <= cap_a;
            skid_b      <= cap_b;
            skid_dest   <= in_dest;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_opcode = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [31:0] in_rs_val = '0;
    logic [31:0] in_rt_val = '0;
    logic [15:0] in_imm = '0;
    logic [4:0]  in_dest = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [4:0]  out_dest;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
    } ent_t;

    ent_t q[$];

    always #5 clock = ~clock;

    alu_operand_stage dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rs_val  (in_rs_val),
        .in_rt_val  (in_rt_val),
        .in_imm     (in_imm),
        .in_dest    (in_dest),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_opcode (alu_opcode),
        .alu_dataA  (alu_dataA),
        .alu_dataB  (alu_dataB),
        .out_dest   (out_dest)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: value a register read would return, with zero register and writeback bypass
    function automatic logic [31:0] read_reg(input logic [4:0] idx, input logic [31:0] rf_val);
        if (idx == 0) return 32'd0;
        if (wb_valid && wb_dest == idx) return wb_data;
        return rf_val;
    endfunction

    function automatic ent_t model_entry();
        ent_t e;
        int   simm;
        simm   = int'($signed(in_imm));
        e.op   = in_opcode;
        e.dest = in_dest;
        e.a    = read_reg(in_rs, in_rs_val);
        if (in_opcode inside {6'b000001, 6'b000011, 6'b000101, 6'b000111, 6'b001010, 6'b010011})
            e.b = 32'(simm);
        else if (in_opcode inside {6'b001100, 6'b001110})
            e.b = 32'(int'(in_imm));
        else
            e.b = read_reg(in_rt, in_rt_val);
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk({tag, ".opcode"}, 32'(alu_opcode), 32'(q[0].op));
            chk({tag, ".dataA"}, alu_dataA, q[0].a);
            chk({tag, ".dataB"}, alu_dataB, q[0].b);
            chk({tag, ".dest"}, 32'(out_dest), 32'(q[0].dest));
        end
    endtask

    // One clock: model decides transfers from pre-edge inputs, then outputs checked at negedge
    task automatic cycle(input string tag);
        ent_t e;
        bit   ix, ox, fl;
        e  = model_entry();
        ix = in_valid && (q.size() < 2);
        ox = (q.size() > 0) && out_ready;
        fl = flush;
        @(posedge clock);
        if (fl) begin
            q.delete();
        end else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(e);
        end
        @(negedge clock);
        check_outputs(tag);
    endtask

    task automatic offer(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] rsv, input logic [31:0] rtv,
                         input logic [15:0] imm, input logic [4:0] dest);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rs_val = rsv;
        in_rt_val = rtv;
        in_imm    = imm;
        in_dest   = dest;
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.opcode", 32'(alu_opcode), 32'd0);
        chk("rst.dataA", alu_dataA, 32'd0);
        chk("rst.dataB", alu_dataB, 32'd0);
        chk("rst.dest", 32'(out_dest), 32'd0);
        reset_n = 1'b1;

        // addi with all-ones immediate: sign extension, 1-cycle latency
        out_ready = 1'b1;
        offer(6'b000001, 5'd3, 5'd0, 32'd5, 32'd0, 16'hFFFF, 5'd9);
        cycle("t1");
        chk("t1.valid", 32'(out_valid), 32'd1);
        chk("t1.a", alu_dataA, 32'd5);
        chk("t1.b", alu_dataB, 32'hFFFF_FFFF);

        // ori zero-extends, register op takes rt
        offer(6'b001110, 5'd1, 5'd2, 32'd7, 32'd8, 16'h8001, 5'd2);
        cycle("t2ori");
        chk("t2ori.b", alu_dataB, 32'h0000_8001);
        offer(6'b000100, 5'd1, 5'd4, 32'd7, 32'hF0, 16'h1234, 5'd3);
        cycle("t2and");
        chk("t2and.b", alu_dataB, 32'hF0);

        // Stall: three offers, only two accepted, then drain in order
        in_valid = 1'b0;
        cycle("t3drain");
        out_ready = 1'b0;
        offer(6'b000000, 5'd1, 5'd2, 32'h11, 32'h12, 16'h0, 5'd11);
        cycle("t3a");
        offer(6'b000010, 5'd1, 5'd2, 32'h21, 32'h22, 16'h0, 5'd12);
        cycle("t3b");
        chk("t3b.in_ready0", 32'(in_ready), 32'd0);
        offer(6'b001000, 5'd1, 5'd2, 32'h31, 32'h32, 16'h0, 5'd13);
        cycle("t3c");
        chk("t3c.held_dest", 32'(out_dest), 32'd11);
        out_ready = 1'b1;
        cycle("t3r1");
        chk("t3r1.dest", 32'(out_dest), 32'd12);
        cycle("t3r2");
        in_valid = 1'b0;
        cycle("t3r3");
        chk("t3r3.dest", 32'(out_dest), 32'd13);
        cycle("t3r4");

        // Writeback forwarding on both sources, and zero register never forwarded
        wb_valid = 1'b1;
        wb_dest  = 5'd7;
        wb_data  = 32'hDEAD;
        offer(6'b000000, 5'd7, 5'd7, 32'd0, 32'd0, 16'h0, 5'd1);
        cycle("t4fwd");
        chk("t4fwd.a", alu_dataA, 32'hDEAD);
        chk("t4fwd.b", alu_dataB, 32'hDEAD);
        wb_dest = 5'd0;
        offer(6'b000000, 5'd0, 5'd0, 32'h123, 32'h456, 16'h0, 5'd1);
        cycle("t4zero");
        chk("t4zero.a", alu_dataA, 32'd0);
        chk("t4zero.b", alu_dataB, 32'd0);
        wb_valid = 1'b0;
        in_valid = 1'b0;
        cycle("t4drain");

        // Flush while full with an offer pending
        out_ready = 1'b0;
        offer(6'b000000, 5'd1, 5'd1, 32'd1, 32'd1, 16'h0, 5'd4);
        cycle("t5a");
        offer(6'b000000, 5'd2, 5'd2, 32'd2, 32'd2, 16'h0, 5'd5);
        cycle("t5b");
        flush = 1'b1;
        offer(6'b000000, 5'd3, 5'd3, 32'd3, 32'd3, 16'h0, 5'd6);
        cycle("t5flush");
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5.out_valid", 32'(out_valid), 32'd0);
        chk("t5.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        cycle("t5after");
        chk("t5after.out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        offer(6'b000011, 5'd1, 5'd0, 32'd9, 32'd0, 16'h8000, 5'd7);
        cycle("t6a");
        #2 reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t6.async_valid", 32'(out_valid), 32'd0);
        chk("t6.async_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;
        offer(6'b001100, 5'd5, 5'd0, 32'h77, 32'd0, 16'hFFFF, 5'd8);
        cycle("t6new");
        chk("t6new.a", alu_dataA, 32'h77);
        chk("t6new.b", alu_dataB, 32'h0000_FFFF);

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_opcode = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) in_opcode = 6'b001100 + 6'($urandom_range(0, 1) * 2);
            in_rs     = 5'($urandom_range(0, 7));
            in_rt     = 5'($urandom_range(0, 7));
            in_rs_val = $urandom;
            in_rt_val = $urandom;
            in_imm    = 16'($urandom);
            in_dest   = 5'($urandom);
            wb_valid  = ($urandom_range(0, 1) == 1);
            wb_dest   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            cycle("rnd");
        end
        flush = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
